// File: rtl/clk_ctrl_if.sv
// Configuration, step button, breakpoint and clock-status bundle of clk_ctrl.
interface clk_ctrl_if #(
  parameter int CNT_W  = 24,
  parameter int ADDR_W = 16
);
  logic [1:0]        cfg_mode;
  logic [CNT_W-1:0]  cfg_div;
  logic              step_btn;
  logic              bp_en;
  logic [ADDR_W-1:0] bp_addr;
  logic [ADDR_W-1:0] pc_addr;
  logic              clk_out;
  logic              halted;
  logic              bp_hit;
  logic [31:0]       cyc_cnt;

  modport master (
    output cfg_mode, cfg_div, step_btn, bp_en, bp_addr, pc_addr,
    input  clk_out, halted, bp_hit, cyc_cnt
  );

  modport slave (
    input  cfg_mode, cfg_div, step_btn, bp_en, bp_addr, pc_addr,
    output clk_out, halted, bp_hit, cyc_cnt
  );
endinterface

// File: rtl/clk_ctrl.sv
// CPU clock controller: full-speed, divided, single-step and halt modes.
// Optional PC breakpoint is built when CLK_CTRL_BP_EN is defined.
module clk_ctrl #(
  parameter int CNT_W  = 24,
  parameter int DEB_W  = 16,
  parameter int ADDR_W = 16
) (
  input  logic      cpu_clk50,
  input  logic      cpu_rst,
  clk_ctrl_if.slave ctrl
);
  typedef enum logic [1:0] {RUN, STOP, STEP_HI, STEP_LO} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, h_q, h_d, h_live, h_cur;
  logic              clk_q, clk_d, bp_hit_q, bp_hit_d;
  logic [31:0]       cyc_q, cyc_d;
  logic [1:0]        sync_q, sync_d;
  logic              filt_q, filt_d, press_q, press_d;
  logic [DEB_W-1:0]  deb_q, deb_d;
  logic [ADDR_W-1:0] pc_l, bpa_l;
  logic              bp_en_l, bp_match, term, stop_req, step_ok;

  assign pc_l  = ctrl.pc_addr;
  assign bpa_l = ctrl.bp_addr;

`ifdef CLK_CTRL_BP_EN
  assign bp_en_l  = ctrl.bp_en;
  assign bp_match = ctrl.bp_en && (pc_l == bpa_l);
`else
  logic unused_bp;
  assign bp_en_l   = 1'b0;
  assign bp_match  = 1'b0;
  assign unused_bp = ^{ctrl.bp_en, pc_l, bpa_l};
`endif

  // Half period is latched on the first cycle of each phase so a cfg change
  // only shapes the following phase.
  assign h_live   = (ctrl.cfg_mode == 2'b00 || ctrl.cfg_div == '0) ? CNT_W'(1) : ctrl.cfg_div;
  assign h_cur    = (cnt_q == '0) ? h_live : h_q;
  assign term     = (cnt_q + CNT_W'(1)) == h_cur;
  assign stop_req = ctrl.cfg_mode[1] || (bp_hit_q && bp_en_l);
  // A press in STOP beats a simultaneous switch to 00/01; only halt blocks it.
  assign step_ok  = press_q && (bp_hit_q || ctrl.cfg_mode != 2'b11);

  always_comb begin
    sync_d  = {sync_q[0], ctrl.step_btn};
    filt_d  = filt_q;
    deb_d   = '0;
    press_d = 1'b0;
    if (sync_q[1] != filt_q) begin
      if (deb_q == '1) begin
        filt_d  = sync_q[1];
        press_d = filt_q;
      end else begin
        deb_d = deb_q + DEB_W'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clk_d    = clk_q;
    cyc_d    = cyc_q;
    bp_hit_d = bp_hit_q;
    h_d      = h_cur;
    unique case (state_q)
      RUN: begin
        if (!term) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
          if (clk_q) begin
            clk_d = 1'b0;
            if (bp_match) bp_hit_d = 1'b1;
          end else begin
            if (!bp_en_l) bp_hit_d = 1'b0;
            if (stop_req) begin
              state_d = STOP;
            end else begin
              clk_d = 1'b1;
              cyc_d = cyc_q + 32'd1;
            end
          end
        end
      end
      STOP: begin
        cnt_d = '0;
        clk_d = 1'b0;
        if (step_ok) begin
          state_d = STEP_HI;
          clk_d   = 1'b1;
          cyc_d   = cyc_q + 32'd1;
        end else if (bp_hit_q && !bp_en_l) begin
          bp_hit_d = 1'b0;
        end else if (!bp_hit_q && !ctrl.cfg_mode[1]) begin
          state_d = RUN;
        end
      end
      STEP_HI: begin
        if (term) begin
          cnt_d   = '0;
          clk_d   = 1'b0;
          state_d = STEP_LO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STEP_LO: begin
        if (term) begin
          cnt_d    = '0;
          state_d  = STOP;
          bp_hit_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge cpu_clk50 or negedge cpu_rst) begin
    if (!cpu_rst) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      h_q      <= '0;
      clk_q    <= 1'b0;
      cyc_q    <= '0;
      bp_hit_q <= 1'b0;
      sync_q   <= '1;
      filt_q   <= 1'b1;
      deb_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      h_q      <= h_d;
      clk_q    <= clk_d;
      cyc_q    <= cyc_d;
      bp_hit_q <= bp_hit_d;
      sync_q   <= sync_d;
      filt_q   <= filt_d;
      deb_q    <= deb_d;
      press_q  <= press_d;
    end
  end

  assign ctrl.clk_out = clk_q;
  assign ctrl.halted  = (state_q == STOP);
  assign ctrl.bp_hit  = bp_hit_q;
  assign ctrl.cyc_cnt = cyc_q;
endmodule

// File: tb/tb_clk_ctrl.sv
// Self-checking bench for clk_ctrl: vector table, directed corner sequences
// and a randomized phase-length reference model.
module tb_clk_ctrl;
  localparam int CNT_W  = 24;
  localparam int DEB_W  = 4;
  localparam int ADDR_W = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  int   tb_rises = 0;

  clk_ctrl_if #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) ctrl ();

  clk_ctrl #(.CNT_W(CNT_W), .DEB_W(DEB_W), .ADDR_W(ADDR_W)) dut (
    .cpu_clk50 (clk),
    .cpu_rst   (rst_n),
    .ctrl      (ctrl)
  );

  always #5 clk = ~clk;

  // The pipeline PC advances once per generated rising edge.
  always @(posedge ctrl.clk_out or negedge rst_n)
    if (!rst_n) tb_rises <= 0;
    else        tb_rises <= tb_rises + 1;

  assign ctrl.pc_addr = tb_rises[ADDR_W-1:0];

  typedef struct {
    logic [1:0] mode;
    int         div;
    int         hi;
    int         lo;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clk(input logic lvl, input int budget, output bit ok);
    int n = 0;
    while (ctrl.clk_out !== lvl && n < budget) begin
      tick();
      n++;
    end
    ok = (ctrl.clk_out === lvl);
  endtask

  task automatic wait_rise(input string name);
    bit ok;
    wait_clk(1'b0, 200, ok);
    if (ok) wait_clk(1'b1, 200, ok);
    if (!ok) check({name, "_timeout"}, ok, 1);
  endtask

  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while (ctrl.clk_out === lvl && n < 500) begin
      n++;
      tick();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ctrl.step_btn = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int hf(input logic [1:0] m, input int d);
    if (m == 2'b00) return 1;
    return (d == 0) ? 1 : d;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n, hi, t_rise, t_halt, r0, len, exp_len, highs;
    bit   ok;
    logic lvl;

    tbl[0] = '{2'b00, 5, 1, 1};
    tbl[1] = '{2'b01, 3, 3, 3};
    tbl[2] = '{2'b01, 0, 1, 1};
    tbl[3] = '{2'b01, 1, 1, 1};
    tbl[4] = '{2'b01, 7, 7, 7};
    tbl[5] = '{2'b00, 9, 1, 1};
    tbl[6] = '{2'b01, 2, 2, 2};

    ctrl.cfg_mode = 2'b00;
    ctrl.cfg_div  = '0;
    ctrl.step_btn = 1'b1;
    ctrl.bp_en    = 1'b0;
    ctrl.bp_addr  = '0;
    rst_n         = 1'b0;
    #1;
    check("rst_clk_out", ctrl.clk_out, 0);
    check("rst_halted", ctrl.halted, 0);
    check("rst_bp_hit", ctrl.bp_hit, 0);
    check("rst_cyc_cnt", ctrl.cyc_cnt, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 1; t <= 20; t++) begin
      tick();
      check("m00_clk", ctrl.clk_out, t % 2);
    end
    check("m00_cyc_cnt", ctrl.cyc_cnt, 10);

    for (int unsigned i = 0; i < 7; i++) begin
      ctrl.cfg_mode = tbl[i].mode;
      ctrl.cfg_div  = CNT_W'(tbl[i].div);
      wait_rise("tbl");
      run_len(1'b1, hi);
      run_len(1'b0, n);
      check("tbl_hi", hi, tbl[i].hi);
      check("tbl_lo", n, tbl[i].lo);
    end

    ctrl.cfg_mode = 2'b01;
    ctrl.cfg_div  = 24'd3;
    wait_rise("div");
    tick();
    ctrl.cfg_div = '0;
    run_len(1'b1, n);
    check("div_switch_hi", n + 1, 3);
    run_len(1'b0, n);
    check("div_after_lo", n, 1);
    run_len(1'b1, n);
    check("div_after_hi", n, 1);

    ctrl.cfg_div = 24'd5;
    wait_rise("halt");
    tick();
    ctrl.cfg_mode = 2'b11;
    run_len(1'b1, n);
    check("halt_hi_len", n + 1, 5);
    n = 0;
    highs = 0;
    while (!ctrl.halted && n < 50) begin
      tick();
      n++;
      if (ctrl.clk_out) highs++;
    end
    check("halt_lo_len", n, 5);
    check("halt_no_runt", highs, 0);
    repeat (10) tick();
    check("halt_stays", ctrl.halted, 1);
    check("halt_clk_low", ctrl.clk_out, 0);

    ctrl.cfg_mode = 2'b10;
    ctrl.cfg_div  = 24'd2;
    r0 = tb_rises;
    highs = 0;
    repeat (3) begin
      ctrl.step_btn = 1'b0;
      repeat (5) begin tick(); if (ctrl.clk_out) highs++; end
      ctrl.step_btn = 1'b1;
      repeat (10) begin tick(); if (ctrl.clk_out) highs++; end
    end
    check("glitch_no_edge", highs, 0);
    check("glitch_rises", tb_rises - r0, 0);
    check("glitch_halted", ctrl.halted, 1);

    r0 = tb_rises;
    t_rise = 0;
    t_halt = 0;
    hi = 0;
    ctrl.step_btn = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (ctrl.clk_out) begin
        hi++;
        if (t_rise == 0) t_rise = t;
      end
      if (t_rise != 0 && t_halt == 0 && ctrl.halted) t_halt = t;
    end
    ctrl.step_btn = 1'b1;
    check("step_latency", t_rise, 2 + (1 << DEB_W) + 1);
    check("step_hi_len", hi, 2);
    check("step_halt_at", t_halt, t_rise + 4);
    check("step_one_edge", tb_rises - r0, 1);
    check("step_cyc_cnt", ctrl.cyc_cnt, tb_rises);
    highs = 0;
    repeat (30) begin tick(); if (ctrl.clk_out) highs++; end
    check("release_no_edge", highs, 0);

    ctrl.step_btn = 1'b0;
    wait_clk(1'b1, 60, ok);
    check("rst_step_reached", ok, 1);
    check("stephi_not_halted", ctrl.halted, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_clk_out", ctrl.clk_out, 0);
    check("midrst_halted", ctrl.halted, 0);
    check("midrst_bp_hit", ctrl.bp_hit, 0);
    check("midrst_cyc_cnt", ctrl.cyc_cnt, 0);
    ctrl.step_btn = 1'b1;
    ctrl.cfg_mode = 2'b01;
    ctrl.cfg_div  = 24'd2;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("restart_lo", ctrl.clk_out, 0);
    tick();
    check("restart_rise", ctrl.clk_out, 1);
    check("restart_cyc", ctrl.cyc_cnt, 1);

`ifdef CLK_CTRL_BP_EN
    ctrl.cfg_mode = 2'b00;
    ctrl.bp_en    = 1'b1;
    ctrl.bp_addr  = 16'h0010;
    do_reset();
    n = 0;
    while (!ctrl.halted && n < 200) begin tick(); n++; end
    check("bp_halted", ctrl.halted, 1);
    check("bp_hit_set", ctrl.bp_hit, 1);
    check("bp_clk_low", ctrl.clk_out, 0);
    check("bp_pc", ctrl.pc_addr, 16'h0010);
    ctrl.step_btn = 1'b0;
    wait_clk(1'b1, 60, ok);
    ctrl.step_btn = 1'b1;
    check("bp_step_rise", ok, 1);
    check("bp_step_pc", ctrl.pc_addr, 16'h0011);
    repeat (4) tick();
    check("bp_cleared", ctrl.bp_hit, 0);
    r0 = tb_rises;
    repeat (20) tick();
    check("bp_resume", tb_rises - r0, 10);
    ctrl.bp_en = 1'b0;
`else
    ctrl.cfg_mode = 2'b00;
    ctrl.bp_en    = 1'b1;
    ctrl.bp_addr  = 16'h0004;
    do_reset();
    repeat (40) tick();
    check("nobp_bp_hit", ctrl.bp_hit, 0);
    check("nobp_halted", ctrl.halted, 0);
    check("nobp_cyc_cnt", ctrl.cyc_cnt, 20);
    ctrl.bp_en = 1'b0;
`endif

    ctrl.cfg_mode = 2'b00;
    ctrl.cfg_div  = '0;
    do_reset();
    wait_rise("rand");
    lvl = 1'b1;
    len = 0;
    exp_len = hf(ctrl.cfg_mode, int'(ctrl.cfg_div));
    for (int unsigned k = 0; k < 600; k++) begin
      tick();
      len++;
      if (ctrl.clk_out !== lvl) begin
        check("rand_phase", len, exp_len);
        lvl = ctrl.clk_out;
        len = 0;
        exp_len = hf(ctrl.cfg_mode, int'(ctrl.cfg_div));
      end else if (len > 10) begin
        check("rand_stuck", len, exp_len);
        lvl = ctrl.clk_out;
        len = 0;
      end else if ($urandom_range(0, 5) == 0) begin
        ctrl.cfg_mode = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b01;
        ctrl.cfg_div  = CNT_W'($urandom_range(0, 4));
      end
    end
    check("rand_cyc_cnt", ctrl.cyc_cnt, tb_rises);
    check("rand_halted", ctrl.halted, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
